// File: rtl/code25_pkg.sv
// rtl/code25_pkg.sv - 2-of-5 code table, idle word and link FSM state encoding
package code25_pkg;

   // Word driven on E1..E5 when no digit is being shown
   localparam logic [4:0] CODE25_IDLE = 5'b00000;

   // E1..E5 per digit, weights 7-4-2-1-0; each word carries exactly two ones
   localparam logic [4:0] CODE25_TABLE [0:9] = '{
      5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
      5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } code25_state_e;

   function automatic logic code25_digit_ok(input logic [3:0] digit);
      return digit <= 4'd9;
   endfunction

endpackage

// File: rtl/code25_lut.sv
// rtl/code25_lut.sv - combinational BCD digit to 2-of-5 word lookup
module code25_lut
   import code25_pkg::*;
(
   input  logic [3:0] digit,
   output logic [4:0] word,
   output logic       invalid
);

   // Out-of-range digits map to the idle word and raise invalid
   always_comb begin
      invalid = !code25_digit_ok(digit);
      word    = CODE25_IDLE;
      if (!invalid) begin
         word = CODE25_TABLE[digit];
      end
   end

endmodule

// File: rtl/code25_tx_encoder.sv
// rtl/code25_tx_encoder.sv - 2-of-5 link transmitter; optional CODE25_TX_AUTOSCAN_EN adds scan_i digit scanner
module code25_tx_encoder
   import code25_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit_i,
   input  logic       valid_i,
`ifdef CODE25_TX_AUTOSCAN_EN
   input  logic       scan_i,
`endif
   output logic       ready_o,
   output logic       E1,
   output logic       E2,
   output logic       E3,
   output logic       E4,
   output logic       E5,
   output logic       word_v_o,
   output logic       err_o
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   code25_state_e  state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [4:0]     word_q, word_d;
   logic           err_q, err_d;
   logic           load;
   logic [3:0]     sel_digit;
   logic [4:0]     lut_word;
   logic           lut_invalid;

   assign ready_o = (state_q == IDLE) && !rst;

`ifdef CODE25_TX_AUTOSCAN_EN
   logic [3:0] scan_q, scan_d;

   // A handshake digit always wins; the scan counter only advances when it is the one sent
   always_comb begin
      load      = ready_o && (valid_i || scan_i);
      sel_digit = valid_i ? digit_i : scan_q;
      scan_d    = scan_q;
      if (ready_o && !valid_i && scan_i) begin
         scan_d = (scan_q == 4'd9) ? 4'd0 : scan_q + 4'd1;
      end
   end

   // Scan digit counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= 4'd0;
      end else begin
         scan_q <= scan_d;
      end
   end
`else
   assign load      = valid_i && ready_o;
   assign sel_digit = digit_i;
`endif

   code25_lut u_lut (
      .digit   (sel_digit),
      .word    (lut_word),
      .invalid (lut_invalid)
   );

   // Next-state logic: accept in IDLE, dwell in HOLD, blank in GAP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      word_d  = word_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (load) begin
               if (lut_invalid) begin
                  err_d = 1'b1;
               end else begin
                  state_d = HOLD;
                  word_d  = lut_word;
               end
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               word_d  = CODE25_IDLE;
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            word_d  = CODE25_IDLE;
            state_d = IDLE;
         end
      endcase
   end

   // State, dwell counter and registered output word
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= CODE25_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   assign {E1, E2, E3, E4, E5} = word_q;
   assign word_v_o = (state_q == HOLD);
   assign err_o    = err_q;

endmodule
